// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the memory-bus arbiter: FSM encoding, master indices
// and the owner/wait-counter widths used by the top and the picker.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    localparam int MASTER_CPU   = 0;
    localparam int MASTER_VIDEO = 1;
    localparam int MASTER_DMA   = 2;

    localparam int WAIT_CNT_W = 4;
    localparam int OWNER_W    = 2;

    function automatic logic [OWNER_W-1:0] onehot_to_idx(input logic [3:0] oh);
        logic [OWNER_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = OWNER_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational winner selection: round-robin starting after last_owner,
// or lowest requesting index when fixed is set.
module rr_pick
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 3
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [OWNER_W-1:0]     last_owner,
    input  logic                   fixed,
    output logic [NUM_MASTERS-1:0] winner,
    output logic                   valid
);

    logic [OWNER_W-1:0] pos;

    // Both loops scan from the least preferred candidate so the last hit wins.
    always_comb begin
        winner = '0;
        pos    = '0;
        valid  = |req;
        if (fixed) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    winner    = '0;
                    winner[i] = 1'b1;
                end
            end
        end else begin
            for (int s = NUM_MASTERS; s >= 1; s--) begin
                pos = OWNER_W'((int'(last_owner) + s) % NUM_MASTERS);
                if (req[pos]) begin
                    winner      = '0;
                    winner[pos] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one 16-bit memory bus between several word-transfer masters with
// req/ack handshakes, programmable wait states and an optional bus lock.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int WAIT_STATES    = 0,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_MASTERS-1:0]    req,
    input  logic [NUM_MASTERS-1:0]    we,
    input  logic [NUM_MASTERS-1:0]    lock,
    input  logic [16*NUM_MASTERS-1:0] addr,
    input  logic [16*NUM_MASTERS-1:0] wdata,
    output logic [NUM_MASTERS-1:0]    gnt,
    output logic [NUM_MASTERS-1:0]    ack,
    output logic [15:0]               rdata,
    output logic                      busy,
    output logic [15:0]               mem_address,
    output logic                      mem_r,
    output logic                      mem_w,
    inout  wire  [15:0]               mem_data
);

    localparam logic [OWNER_W-1:0]    RESET_OWNER = OWNER_W'(NUM_MASTERS - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD   = WAIT_CNT_W'(WAIT_STATES);

    arb_state_t             state_reg, state_next;
    logic [OWNER_W-1:0]     owner_reg, last_owner_reg;
    logic                   locked_reg;
    logic [WAIT_CNT_W-1:0]  cnt_reg;
    logic [15:0]            addr_reg, wdata_reg, rdata_reg;
    logic                   we_reg;
    logic [NUM_MASTERS-1:0] gnt_reg;

    logic [NUM_MASTERS-1:0] pick_winner;
    logic                   pick_valid;
    logic                   lock_hold, lock_release, win_valid;
    logic [OWNER_W-1:0]     win_idx;

    logic [15:0] addr_arr  [NUM_MASTERS];
    logic [15:0] wdata_arr [NUM_MASTERS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_slice
            assign addr_arr[gi]  = addr[16*gi +: 16];
            assign wdata_arr[gi] = wdata[16*gi +: 16];
        end
    endgenerate

    rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
        .req        (req),
        .last_owner (last_owner_reg),
        .fixed      (FIXED_PRIORITY != 0),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    // A held lock only binds while its owner keeps requesting; otherwise the
    // lock is released and normal arbitration runs in the same cycle.
    always_comb begin
        lock_hold    = locked_reg && req[last_owner_reg];
        lock_release = locked_reg && (|req) && !req[last_owner_reg];
        win_valid    = lock_hold || pick_valid;
        win_idx      = lock_hold ? last_owner_reg : onehot_to_idx(4'(pick_winner));
    end

    always_comb begin
        state_next  = state_reg;
        gnt         = gnt_reg;
        ack         = '0;
        rdata       = rdata_reg;
        busy        = (state_reg != ARB_IDLE);
        mem_address = addr_reg;
        mem_r       = 1'b0;
        mem_w       = 1'b0;
        case (state_reg)
            ARB_IDLE: begin
                if (win_valid) state_next = ARB_ACCESS;
            end
            ARB_ACCESS: begin
                mem_r = !we_reg;
                mem_w = we_reg;
                if (cnt_reg == '0) state_next = ARB_DONE;
            end
            ARB_DONE: begin
                ack        = gnt_reg;
                state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    assign mem_data = mem_w ? wdata_reg : 'z;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ARB_IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_reg      <= '0;
            last_owner_reg <= RESET_OWNER;
            locked_reg     <= 1'b0;
            cnt_reg        <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            we_reg         <= 1'b0;
            gnt_reg        <= '0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (lock_release) locked_reg <= 1'b0;
                    if (win_valid) begin
                        owner_reg <= win_idx;
                        gnt_reg   <= NUM_MASTERS'(1) << win_idx;
                        addr_reg  <= addr_arr[win_idx];
                        wdata_reg <= wdata_arr[win_idx];
                        we_reg    <= we[win_idx];
                        cnt_reg   <= WAIT_LOAD;
                    end
                end
                ARB_ACCESS: begin
                    if (cnt_reg == '0) begin
                        if (!we_reg) rdata_reg <= mem_data;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ARB_DONE: begin
                    last_owner_reg <= owner_reg;
                    locked_reg     <= lock[owner_reg];
                    gnt_reg        <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Three arbiters (WS=0 round-robin, WS=2 round-robin, WS=0 fixed priority)
// share one directed stimulus and are checked every cycle against a step model.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int NM = 3;
    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  we_bus = '0;
    logic [2:0]  lock_bus = '0;
    logic [47:0] addr_bus = '0;
    logic [47:0] wdata_bus = '0;

    int issued [NM];
    int served [NI][NM];

    logic [2:0]  gnt_v   [NI];
    logic [2:0]  ack_v   [NI];
    logic [15:0] rdata_v [NI];
    logic [15:0] maddr_v [NI];
    logic [15:0] md_v    [NI];
    logic        busy_v  [NI];
    logic        mr_v    [NI];
    logic        mw_v    [NI];

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    logic [31:0] ord     [NI];
    int          ack_cyc [NI];
    int          scnt    [NI];
    logic [15:0] wseen   [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return (a == 16'h0123) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction

    function automatic int ws_of(input int i);
        return (i == 1) ? 2 : 0;
    endfunction

    function automatic int fp_of(input int i);
        return (i == 2) ? 1 : 0;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            wire  [15:0] md;
            logic [2:0]  rq;
            assign rq = {issued[2] > served[gi][2], issued[1] > served[gi][1], issued[0] > served[gi][0]};
            assign md = mr_v[gi] ? mem_fn(maddr_v[gi]) : 16'bz;
            assign md_v[gi] = md;
            bus_arbiter #(
                .NUM_MASTERS    (NM),
                .WAIT_STATES    ((gi == 1) ? 2 : 0),
                .FIXED_PRIORITY ((gi == 2) ? 1 : 0)
            ) u_dut (
                .clk         (clk),
                .reset       (reset),
                .req         (rq),
                .we          (we_bus),
                .lock        (lock_bus),
                .addr        (addr_bus),
                .wdata       (wdata_bus),
                .gnt         (gnt_v[gi]),
                .ack         (ack_v[gi]),
                .rdata       (rdata_v[gi]),
                .busy        (busy_v[gi]),
                .mem_address (maddr_v[gi]),
                .mem_r       (mr_v[gi]),
                .mem_w       (mw_v[gi]),
                .mem_data    (md)
            );
        end
    endgenerate

    // ---------------- behavioural model ----------------
    // mk = cycles since grant: 0 idle, 1..WS+1 strobes, WS+2 ack.
    int          mk    [NI];
    int          mown  [NI];
    int          mlast [NI];
    logic        mlk   [NI];
    logic        mwe   [NI];
    logic [15:0] mla   [NI];
    logic [15:0] mwd   [NI];
    logic [15:0] mrd   [NI];

    function automatic logic [2:0] req_of(input int i);
        logic [2:0] r;
        r = '0;
        for (int m = 0; m < NM; m++)
            if (issued[m] > served[i][m]) r = r | (3'b001 << m);
        return r;
    endfunction

    function automatic logic bit_of(input logic [2:0] v, input int m);
        return ((v >> m) & 3'b001) != 3'b000;
    endfunction

    function automatic int model_winner(input int i);
        logic [2:0] r;
        r = req_of(i);
        if (mlk[i] && bit_of(r, mlast[i])) return mlast[i];
        if (fp_of(i) != 0) begin
            for (int m = 0; m < NM; m++) if (bit_of(r, m)) return m;
        end else begin
            for (int s = 1; s <= NM; s++) if (bit_of(r, (mlast[i] + s) % NM)) return (mlast[i] + s) % NM;
        end
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                mk[i] <= 0; mown[i] <= 0; mlast[i] <= NM - 1; mlk[i] <= 1'b0;
                mwe[i] <= 1'b0; mla[i] <= '0; mwd[i] <= '0; mrd[i] <= '0;
            end else if (mk[i] == 0) begin
                if (req_of(i) != 3'b000) begin
                    if (mlk[i] && !bit_of(req_of(i), mlast[i])) mlk[i] <= 1'b0;
                    mown[i] <= model_winner(i);
                    mla[i]  <= 16'(addr_bus >> (16 * model_winner(i)));
                    mwd[i]  <= 16'(wdata_bus >> (16 * model_winner(i)));
                    mwe[i]  <= bit_of(we_bus, model_winner(i));
                    mk[i]   <= 1;
                end
            end else if (mk[i] <= ws_of(i)) begin
                mk[i] <= mk[i] + 1;
            end else if (mk[i] == ws_of(i) + 1) begin
                if (!mwe[i]) mrd[i] <= mem_fn(mla[i]);
                mk[i] <= mk[i] + 1;
            end else begin
                mlast[i] <= mown[i];
                mlk[i]   <= bit_of(lock_bus, mown[i]);
                mk[i]    <= 0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst=%0d actual=%0h expected=%0h cyc=%0d", nm, i, act, exp, cyc);
        end
    endtask

    task automatic tick();
        logic [2:0] eg;
        logic       acc;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            eg  = (mk[i] != 0) ? (3'b001 << mown[i]) : 3'b000;
            acc = (mk[i] >= 1) && (mk[i] <= ws_of(i) + 1);
            chk("gnt",   i, 32'(gnt_v[i]),   32'(eg));
            chk("ack",   i, 32'(ack_v[i]),   32'((mk[i] == ws_of(i) + 2) ? eg : 3'b000));
            chk("mem_r", i, 32'(mr_v[i]),    32'(acc && !mwe[i]));
            chk("mem_w", i, 32'(mw_v[i]),    32'(acc && mwe[i]));
            chk("busy",  i, 32'(busy_v[i]),  32'(mk[i] != 0));
            chk("rdata", i, 32'(rdata_v[i]), 32'(mrd[i]));
            chk("maddr", i, 32'(maddr_v[i]), 32'(mla[i]));
            if (acc && mwe[i]) chk("mem_data", i, 32'(md_v[i]), 32'(mwd[i]));
        end
        for (int i = 0; i < NI; i++) begin
            if (mr_v[i] || mw_v[i]) scnt[i]++;
            if (mw_v[i]) wseen[i] = md_v[i];
            for (int m = 0; m < NM; m++) begin
                if (ack_v[i][m]) begin
                    served[i][m]++;
                    ord[i]     = {ord[i][27:0], 4'(m + 1)};
                    ack_cyc[i] = cyc;
                    $display("[TB] inst%0d cyc %0d ack master %0d addr %h rdata %h", i, cyc, m, maddr_v[i], rdata_v[i]);
                end
            end
        end
    endtask

    function automatic logic all_idle();
        for (int i = 0; i < NI; i++) begin
            if (mk[i] != 0) return 1'b0;
            for (int m = 0; m < NM; m++) if (served[i][m] != issued[m]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_all(input string nm, input int budget);
        int n;
        n = 0;
        while (!all_idle() && n < budget) begin
            tick();
            n++;
        end
        chk(nm, -1, 32'(all_idle()), 32'd1);
    endtask

    task automatic issue(input int m, input logic w, input logic [15:0] a, input logic [15:0] d, input int n);
        we_bus[m]            = w;
        addr_bus[16*m +: 16] = a;
        wdata_bus[16*m +: 16] = d;
        issued[m]            += n;
    endtask

    task automatic clear_log();
        for (int i = 0; i < NI; i++) begin
            ord[i] = '0; scnt[i] = 0; wseen[i] = '0; ack_cyc[i] = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        for (int m = 0; m < NM; m++) begin
            issued[m] = 0;
            for (int i = 0; i < NI; i++) served[i][m] = 0;
        end
        clear_log();

        repeat (3) tick();
        chk("rst_gnt", 0, 32'(gnt_v[0]), 32'd0);
        chk("rst_rdata", 1, 32'(rdata_v[1]), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // CPU read of 0x0123, memory answers 0xBEEF
        clear_log();
        t0 = cyc;
        issue(MASTER_CPU, 1'b0, 16'h0123, 16'h0000, 1);
        wait_all("drain_t1", 50);
        chk("t1_rdata", 0, 32'(rdata_v[0]), 32'hBEEF);
        chk("t1_lat",   0, 32'(ack_cyc[0] - t0), 32'd2);
        chk("t1_lat",   1, 32'(ack_cyc[1] - t0), 32'd4);
        chk("t1_strb",  0, 32'(scnt[0]), 32'd1);

        // DMA write 0x55AA to 0x07FF
        clear_log();
        t0 = cyc;
        issue(MASTER_DMA, 1'b1, 16'h07FF, 16'h55AA, 1);
        wait_all("drain_t2", 50);
        chk("t2_lat",   1, 32'(ack_cyc[1] - t0), 32'd4);
        chk("t2_strb",  1, 32'(scnt[1]), 32'd3);
        chk("t2_data",  1, 32'(wseen[1]), 32'h55AA);
        chk("t2_rdata", 1, 32'(rdata_v[1]), 32'hBEEF);
        chk("t2_order", 1, ord[1], 32'h3);

        // all three masters, two reads each
        clear_log();
        issue(MASTER_CPU,   1'b0, 16'h1000, 16'h0000, 2);
        issue(MASTER_VIDEO, 1'b0, 16'h2000, 16'h0000, 2);
        issue(MASTER_DMA,   1'b0, 16'h3000, 16'h0000, 2);
        wait_all("drain_t3", 200);
        chk("t3_order_rr",  0, ord[0], 32'h123123);
        chk("t3_order_rr",  1, ord[1], 32'h123123);
        chk("t3_order_fix", 2, ord[2], 32'h112233);
        chk("t3_rdata",     0, 32'(rdata_v[0]), 32'h6A5A);

        // locked CPU does two writes before video gets in
        clear_log();
        lock_bus[MASTER_CPU] = 1'b1;
        issue(MASTER_CPU,   1'b1, 16'h0100, 16'h1111, 2);
        issue(MASTER_VIDEO, 1'b0, 16'h0200, 16'h0000, 1);
        wait_all("drain_t4", 200);
        chk("t4_order", 0, ord[0], 32'h112);
        chk("t4_order", 1, ord[1], 32'h112);

        // lock released: video is served between the CPU transfers
        clear_log();
        lock_bus[MASTER_CPU] = 1'b0;
        issue(MASTER_CPU,   1'b1, 16'h0101, 16'h2222, 2);
        issue(MASTER_VIDEO, 1'b0, 16'h0201, 16'h0000, 1);
        wait_all("drain_t5", 200);
        chk("t5_order",     0, ord[0], 32'h121);
        chk("t5_order",     1, ord[1], 32'h121);
        chk("t5_order_fix", 2, ord[2], 32'h112);

        // reset during a write access
        clear_log();
        issue(MASTER_CPU, 1'b1, 16'h0400, 16'hA5A5, 1);
        tick();
        tick();
        chk("t6_pre_mw", 1, 32'(mw_v[1]), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_mw",  1, 32'(mw_v[1]), 32'd0);
        chk("t6_rst_gnt", 1, 32'(gnt_v[1]), 32'd0);
        chk("t6_rst_ack", 1, 32'(ack_v[1]), 32'd0);
        issue(MASTER_DMA, 1'b0, 16'h0500, 16'h0000, 1);
        tick();
        tick();
        chk("t6_noack", 1, ord[1], 32'h0);
        reset = 1'b0;
        wait_all("drain_t6", 100);
        chk("t6_order", 0, ord[0], 32'h13);
        chk("t6_order", 1, ord[1], 32'h13);
        chk("t6_order", 2, ord[2], 32'h13);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
